// File: rtl/alu_seq_n_bits_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the multi-cycle opcode test.
// Optional multiplier is enabled by defining ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_LSR  = 4'd5,
    OP_LSL  = 4'd6,
    OP_MOD  = 4'd7,
    OP_PASS = 4'd8,
    OP_DIV  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_e;

  function automatic logic is_multicycle(op_e op);
`ifdef ALU_SEQ_MUL_EN
    return (op == OP_MOD) || (op == OP_DIV) || (op == OP_MUL);
`else
    return (op == OP_MOD) || (op == OP_DIV);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_n_bits_if.sv
// Request/result bundle between the controller (master) and the sequential ALU (slave).
interface alu_seq_n_bits_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   control;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         v;
  logic         c;
  logic         n;
  logic         z;
  logic         dz;

  modport master (
    output start, a, b, control,
    input  busy, done, result, v, c, n, z, dz
  );

  modport slave (
    input  start, a, b, control,
    output busy, done, result, v, c, n, z, dz
  );
endinterface

// File: rtl/alu_seq_n_bits_divider.sv
// Iterative unsigned restoring divider: load once, then one quotient bit per step (MSB first).
module seq_divider_n_bits #(parameter int N = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);
  logic [N-1:0] quo_q, quo_d;
  logic [N-1:0] rem_q, rem_d;
  logic [N-1:0] dvs_q, dvs_d;
  logic [N:0]   shifted;
  logic [N:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, quo_q[N-1]};
    // Partial remainder is always < 2*divisor, so bit N of trial is a clean borrow.
    trial   = shifted - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (!trial[N]) begin
        rem_d = trial[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b1};
      end else begin
        rem_d = shifted[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_seq_n_bits.sv
// Registered, handshaked N-bit ALU with iterative div/mod and optional shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 10 is treated as illegal.
module alu_seq_n_bits
  import alu_seq_pkg::*;
#(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst_n,
  alu_seq_n_bits_if.slave bus
);
  localparam int           CW        = $clog2(N);
  localparam logic [N-1:0] SHIFT_LIM = N'(N);

  state_e       state_q, state_d;
  op_e          op_q, op_d, start_op;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [N-1:0] result_q, result_d;
  logic         v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, dz_q, dz_d;
  logic         start_dz, div_load, div_step;
  logic [N-1:0] div_quo, div_rem;
  logic [N-1:0] alu_res;
  logic         alu_v, alu_c, alu_dz;
  logic [N:0]   sum_add, sum_sub;
`ifdef ALU_SEQ_MUL_EN
  logic [2*N-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [N-1:0]   mplier_q, mplier_d;
`endif

  seq_divider_n_bits #(.N(N)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign start_op = op_e'(bus.control);
  assign start_dz = ((start_op == OP_DIV) || (start_op == OP_MOD)) && (bus.b == '0);
  assign sum_add  = {1'b0, a_q} + {1'b0, b_q};
  assign sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};

  // Result decode from the latched operands; only sampled in FIN.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_add[N-1:0];
        alu_c   = sum_add[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_res = sum_sub[N-1:0];
        alu_c   = sum_sub[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_LSR:  alu_res = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q);
      OP_LSL:  alu_res = (b_q >= SHIFT_LIM) ? '0 : (a_q << b_q);
      OP_PASS: alu_res = a_q;
      OP_MOD: begin
        alu_dz  = (b_q == '0);
        alu_res = alu_dz ? a_q : div_rem;
      end
      OP_DIV: begin
        alu_dz  = (b_q == '0);
        alu_res = alu_dz ? '1 : div_quo;
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        alu_res = prod_q[N-1:0];
        alu_c   = |prod_q[2*N-1:N];
        alu_v   = |prod_q[2*N-1:N];
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    v_d      = v_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    dz_d     = dz_q;
    div_load = 1'b0;
    div_step = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          op_d   = start_op;
          busy_d = 1'b1;
          if (is_multicycle(start_op) && !start_dz) begin
            state_d  = ST_CALC;
            cnt_d    = CW'(N - 1);
            div_load = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            mcand_d  = {{N{1'b0}}, bus.a};
            mplier_d = bus.b;
            prod_d   = '0;
`endif
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_CALC: begin
        div_step = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = ST_FIN;
      end
      ST_FIN: begin
        result_d = alu_res;
        v_d      = alu_v;
        c_d      = alu_c;
        n_d      = alu_res[N-1];
        z_d      = (alu_res == '0);
        dz_d     = alu_dz;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      dz_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      v_q      <= v_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      dz_q     <= dz_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.v      = v_q;
  assign bus.c      = c_q;
  assign bus.n      = n_q;
  assign bus.z      = z_q;
  assign bus.dz     = dz_q;
endmodule

// File: doc/alu_seq_n_bits.md
Name: alu_seq_n_bits

Overview:
- Registered, handshaked successor of the combinational N-bit ALU.
- Adds multi-cycle division and modulo via an iterative restoring divider, and an optional multi-cycle shift-add multiplier.
- Operands and opcode are latched on a start strobe. Result and flags are registered and held until the next completed operation.
- Sits between the lab control FSM / register file and the display/flag logic.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- a  in  N  operand A (unsigned for div/mod/mul)
- b  in  N  operand B
- control  in  4  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lsr, 6 lsl, 7 mod, 8 pass a, 9 div, 10 mul (optional), 11-15 illegal
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result/flags valid from this cycle
- result  out  N  registered result
- v  out  1  overflow flag
- c  out  1  carry flag
- n  out  1  negative flag, result[N-1]
- z  out  1  zero flag, result==0
- dz  out  1  divide-by-zero flag (ops 7, 9 only)

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). rst_n=0 forces state IDLE and busy=done=0. result, v, c, n, z and dz are all forced to 0. Internal divider/multiplier registers are cleared.
- Reset mid-operation: the operation is aborted and no done pulse is issued. After release the block is in IDLE and accepts start on the first edge.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 latches a, b and control, and sets busy=1.
  - Single-cycle ops (0-6, 8), illegal opcodes and divide-by-zero go directly to FIN.
  - Ops 7, 9 and 10 go to CALC with the iteration counter at N-1.
- CALC: one divider/multiplier iteration per cycle. The counter decrements; at 0, go to FIN. This gives exactly N cycles in CALC.
- FIN:
  - Registers result and flags, pulses done=1 and sets busy=0, then returns to IDLE.
  - start in the FIN cycle is ignored.
- Latency, start edge to done high:
  - single-cycle ops: 2 cycles
  - div, mod, mul: N+2 cycles
- start while busy=1 is ignored; the latched operands are never modified mid-operation.
- Add/sub: N-bit two's complement (sub = a + ~b + 1).
  - c = carry out (sub: 1 means no borrow).
  - v = signed overflow.
- Other ops: v=c=0, except mul.
- Shifts: logical. If the shift amount b >= N, the result is 0.
- Div/mod: unsigned restoring division; div gives the quotient, mod the remainder.
- b=0 on div/mod: no iteration, FIN after 1 cycle.
  - div: result all ones.
  - mod: result = a.
  - dz=1.
  - dz=0 for every other completed op.
- Mul: unsigned, result = low N bits of the 2N-bit product. c = v = (high N bits != 0).
- Illegal opcode: result=0, z=1, other flags 0; done is still issued.
- Outputs hold their values between done pulses.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: opcode 10 performs the N-cycle shift-add multiply described above.
- Undefined: the multiplier hardware is absent and opcode 10 is handled as an illegal opcode (2-cycle latency, result 0, z=1).

Decomposition:
- Package alu_seq_pkg:
  - opcode enum (OP_ADD ... OP_MUL)
  - FSM state enum
  - function is_multicycle(op)
- Sub-module seq_divider_n_bits (parameter N): load, step, quotient and remainder registers. It is instantiated once and shared by div and mod.
- Multiplier iteration stays inline under the macro.

Test Plan (N=8):
- Add: a=8'h7F, b=8'h01, op 0 -> done at cycle 2; result 8'h80, v=1, n=1, c=0, z=0.
- Sub: a=8'h05, b=8'h05, op 1 -> result 8'h00, z=1, c=1, v=0.
- Div/mod: a=200, b=7.
  - op 9 -> busy for 10 cycles, done at cycle 10; result 28.
  - op 7 -> result 4.
  - start pulsed mid-operation is ignored.
- Div by zero: a=8'h2A, b=0.
  - op 9 -> result 8'hFF, dz=1, done at cycle 2.
  - op 7 -> result 8'h2A, dz=1.
- Reset: assert rst_n=0 during CALC of a div -> no done pulse; all outputs 0. A new add after release completes normally.
- Mul: a=16, b=20, op 10.
  - With ALU_SEQ_MUL_EN: result 8'h40, c=v=1, done at cycle 10.
  - Without the macro: result 0, z=1, done at cycle 2.
